// File: rtl/rns_64_63_47_pkg.sv
// ============================================================
// rns_64_63_47_pkg : moduli, inverses, weights and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package rns_64_63_47_pkg;

  localparam int M_64          = 64;
  localparam int M_63          = 63;
  localparam int M_47          = 47;
  localparam int INV_64_MOD_63 = 1;
  localparam int INV_64_MOD_47 = 36;
  localparam int INV_63_MOD_47 = 3;
  localparam int W3            = 4032;
  localparam int M_TOTAL       = 189504;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A2   = 3'd1;
  localparam logic [2:0] ST_A3M  = 3'd2;
  localparam logic [2:0] ST_A3F  = 3'd3;
  localparam logic [2:0] ST_ACC  = 3'd4;
  localparam logic [2:0] ST_OUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_A2   = ST_A2,
    S_A3M  = ST_A3M,
    S_A3F  = ST_A3F,
    S_ACC  = ST_ACC,
    S_OUT  = ST_OUT
  } conv_state_t;

  // (a - b) mod m for a <= 63, b < m, via a 7-bit signed difference
  function automatic logic [5:0] sub_wrap(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] m);
    logic signed [6:0] d;
    d = signed'({1'b0, a}) - signed'({1'b0, b});
    if (d < 0) d = d + signed'({1'b0, m});
    return 6'(d);
  endfunction

  function automatic logic [5:0] red_once(input logic [5:0] a, input logic [5:0] m);
    return (a >= m) ? 6'(a - m) : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rns_64_63_47_to_bin_mod47_fold.sv
// ============================================================
// mod47_fold : combinational 12-bit -> mod 47 reduction (64 = 17 mod 47)
// Rev 1.0
// ============================================================
`default_nettype none

module mod47_fold (
  input  logic [11:0] a,
  output logic [5:0]  y
);

  logic [10:0] s1;
  logic [8:0]  s2;
  logic [7:0]  s3;
  logic [6:0]  s4;

  // Each fold replaces hi*64 with hi*17; three folds bring the value under 183
  always_comb begin
    s1 = 11'(a[11:6]) * 11'd17 + 11'(a[5:0]);
    s2 = 9'(s1[10:6]) * 9'd17 + 9'(s1[5:0]);
    s3 = 8'(s2[8:6]) * 8'd17 + 8'(s2[5:0]);
    s4 = (s3 >= 8'd94) ? 7'(s3 - 8'd94) : 7'(s3);
    y  = (s4 >= 7'd47) ? 6'(s4 - 7'd47) : 6'(s4);
  end

endmodule

`default_nettype wire

// File: rtl/rns_64_63_47_to_bin.sv
// ============================================================
// rns_64_63_47_to_bin : multi-cycle MRC reverse converter {64,63,47}
// Rev 1.0 -- optional input range check: RNS_IN_CHECK_EN
// ============================================================
`default_nettype none

module rns_64_63_47_to_bin
  import rns_64_63_47_pkg::*;
#(
  parameter int OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       r64,
  input  logic [5:0]       r63,
  input  logic [5:0]       r47,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] x_out,
  output logic             err
);

  conv_state_t state;
  logic [5:0]  c64, c63, c47;
  logic [5:0]  a1, a2, t, a3;
  logic [17:0] x_reg;

  logic [5:0]  d_t, d_a3, t_next, a3_next;
  logic [11:0] prod_t, prod_a3;
  logic [17:0] x_sum;

  always_comb begin
    d_t     = sub_wrap(c47, red_once(a1, 6'(M_47)), 6'(M_47));
    prod_t  = 12'(d_t) * 12'(INV_64_MOD_47);
    d_a3    = sub_wrap(t, red_once(a2, 6'(M_47)), 6'(M_47));
    prod_a3 = 12'(d_a3) * 12'(INV_63_MOD_47);
    x_sum   = 18'(a1) + (18'(a2) << 6) + 18'(a3) * 18'(W3);
  end

  mod47_fold u_fold_t (
    .a (prod_t),
    .y (t_next)
  );

  mod47_fold u_fold_a3 (
    .a (prod_a3),
    .y (a3_next)
  );

`ifdef RNS_IN_CHECK_EN
  logic flag;
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag    <= 1'b0;
      err_reg <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      flag <= (r63 == 6'd63) || (r47 >= 6'd47);
    end else if (state == S_ACC) begin
      err_reg <= flag;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      c64   <= '0;
      c63   <= '0;
      c47   <= '0;
      a1    <= '0;
      a2    <= '0;
      t     <= '0;
      a3    <= '0;
      x_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            c64   <= r64;
            c63   <= r63;
            c47   <= r47;
            state <= S_A2;
          end
        end
        S_A2: begin
          // 64^-1 mod 63 is 1, so a2 is just the wrapped difference
          a1    <= c64;
          a2    <= sub_wrap(c63, red_once(c64, 6'(M_63)), 6'(M_63));
          state <= S_A3M;
        end
        S_A3M: begin
          t     <= t_next;
          state <= S_A3F;
        end
        S_A3F: begin
          a3    <= a3_next;
          state <= S_ACC;
        end
        S_ACC: begin
`ifdef RNS_IN_CHECK_EN
          x_reg <= flag ? '0 : x_sum;
`else
          x_reg <= x_sum;
`endif
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  generate
    if (OUT_W > 18) begin : g_out_pad
      assign x_out = {{(OUT_W-18){1'b0}}, x_reg};
    end else begin : g_out_exact
      assign x_out = x_reg;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rns_64_63_47_to_bin.sv
// ============================================================
// tb_rns_64_63_47_to_bin : scoreboard bench for the MRC converter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_rns_64_63_47_to_bin;

  localparam int M = 189504;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  r64, r63, r47;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] x_out;
  logic        err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  bit          stall_mode  = 1'b0;
  bit          ready_level = 1'b1;
  bit          rnd_bit     = 1'b1;

  rns_64_63_47_to_bin #(.OUT_W(18)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r64       (r64),
    .r63       (r63),
    .r47       (r47),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign out_ready = stall_mode ? rnd_bit : ready_level;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one pop per output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("x_out", 32'(x_out), 32'(e[17:0]));
        check("err", 32'(err), 32'(e[31]));
      end
    end
  end

  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                      input logic [17:0] exp_x, input logic exp_err);
    bit acc;
    acc      = 1'b0;
    r64      = a;
    r63      = b;
    r47      = c;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_err, 13'd0, exp_x});
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_x(input int x);
    send(6'(x % 64), 6'(x % 63), 6'(x % 47), 18'(x), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_out", 32'(got), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    r64      = '0;
    r63      = '0;
    r47      = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_a2", 32'(dut.a2), 32'd0);
    check("rst_a3", 32'(dut.a3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept edge then four more edges to OUT
    r64 = 6'd0; r63 = 6'd0; r47 = 6'd0;
    in_valid = 1'b1;
    exp_q.push_back(32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check("latency", 32'(out_valid), 32'(e == 4));
    end
    drain();

    send(6'd32, 6'd19, 6'd31, 18'd100000, 1'b0);
    wait_out();
    check("a2_int", 32'(dut.a2), 32'd50);
    check("a3_int", 32'(dut.a3), 32'd24);
    drain();

    send(6'd63, 6'd62, 6'd46, 18'd189503, 1'b0);
    send(6'd1, 6'd1, 6'd1, 18'd1, 1'b0);
    drain();

    // Stall in OUT; a second triple offered meanwhile must be ignored
    ready_level = 1'b0;
    send_x(12345);
    wait_out();
    r64 = 6'd5; r63 = 6'd5; r47 = 6'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_x", 32'(x_out), 32'd12345);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);
    check("x_keep", 32'(x_out), 32'd12345);
    check("ignored_q", 32'(exp_q.size()), 32'd0);
    send_x(7);
    drain();

    // Reset asserted while the FSM is in A3M
    send_x(20000);
    drain();
    r64 = 6'd2; r63 = 6'd2; r47 = 6'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_x", 32'(x_out), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(6'd1, 6'd1, 6'd1, 18'd1, 1'b0);
    drain();

`ifdef RNS_IN_CHECK_EN
    send(6'd5, 6'd5, 6'd47, 18'd0, 1'b1);
    send(6'd1, 6'd1, 6'd1, 18'd1, 1'b0);
    send(6'd0, 6'd63, 6'd0, 18'd0, 1'b1);
    drain();
`endif

    // Random sample of X with random consumer stalls
    stall_mode = 1'b1;
    send_x(0);
    send_x(M - 1);
    send_x(63);
    send_x(64);
    send_x(4031);
    send_x(4032);
    for (int i = 0; i < 300; i++) send_x(int'($urandom_range(0, M - 1)));
    drain();
    stall_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
